// File: rtl/magic_device_read_arbiter.sv
// Round-robin arbiter sharing the MagicDeviceBlackbox read port between NREQ
// requesters, with one read outstanding at a time and a response timeout.
module magic_device_read_arbiter #(
  parameter int                NREQ     = 4,
  parameter int                SEL_W    = 12,
  parameter int                DATA_W   = 64,
  parameter int                TIMEOUT  = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA = 64'hDEAD_DEAD_DEAD_DEAD
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*SEL_W-1:0]   req_select,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         resp_valid,
  output logic [DATA_W-1:0]       resp_data,
  output logic                    resp_err,
  output logic [SEL_W-1:0]        dev_read_select,
  output logic                    dev_read_ready,
  input  logic                    dev_read_valid,
  input  logic [DATA_W-1:0]       dev_read_data,
  output logic                    spurious
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gnt;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] win;
  logic             any_req;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PTR_W'(s);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[wrap_add(rr_ptr, i)]) begin
        win     = wrap_add(rr_ptr, i);
        any_req = 1'b1;
      end
    end
  end

  // Gated by reset so no requester sees an acceptance while the block is held in reset.
  assign req_ready = (reset && state == IDLE && any_req) ? onehot(win) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      gnt             <= '0;
      cnt             <= '0;
      resp_valid      <= '0;
      resp_data       <= '0;
      resp_err        <= 1'b0;
      dev_read_select <= '0;
      dev_read_ready  <= 1'b0;
      spurious        <= 1'b0;
    end else begin
      resp_valid     <= '0;
      resp_data      <= '0;
      resp_err       <= 1'b0;
      dev_read_ready <= 1'b0;
      spurious       <= dev_read_valid && (state == IDLE || state == RESP);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (any_req) begin
            gnt             <= win;
            dev_read_select <= req_select[int'(win) * SEL_W +: SEL_W];
            dev_read_ready  <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          // The counter measures cycles since the issue strobe.
          cnt <= CNT_W'(1);
          if (dev_read_valid) begin
            resp_valid <= onehot(gnt);
            resp_data  <= dev_read_data;
            state      <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
          if (dev_read_valid) begin
            resp_valid <= onehot(gnt);
            resp_data  <= dev_read_data;
            state      <= RESP;
          end else if (TIMEOUT != 0 && cnt >= CNT_W'(TIMEOUT - 1)) begin
            resp_valid <= onehot(gnt);
            resp_data  <= ERR_DATA;
            resp_err   <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          cnt    <= '0;
          rr_ptr <= wrap_add(gnt, 1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
